// File: rtl/gcd_engine.sv
// GCD engine: valid/ready wrapped controller plus operand datapath, computing gcd(in_a, in_b)
// with either subtractive Euclid (ALGO=0) or binary Stein (ALGO=1), one iteration per cycle.
module gcd_engine #(
    parameter int WIDTH     = 16,
    parameter int ALGO      = 0,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 abort,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_gcd,
    output logic [CNT_WIDTH-1:0] out_cycles
);

    localparam int K_WIDTH = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } stateType;

    stateType             state;
    stateType             stateNext;
    logic [WIDTH-1:0]     opA;
    logic [WIDTH-1:0]     opB;
    logic [WIDTH-1:0]     opANext;
    logic [WIDTH-1:0]     opBNext;
    logic [K_WIDTH-1:0]   shiftK;
    logic [K_WIDTH-1:0]   shiftKNext;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cntInc;
    logic [WIDTH-1:0]     resultValue;
    logic                 finish;

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // NOTE: every combinational output gets a default first, otherwise a latch is inferred.
    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE:    if (in_valid) stateNext = RUN;
            RUN: begin
                if (abort) begin
                    stateNext = IDLE;
                end else if (finish) begin
                    stateNext = DONE;
                end
            end
            DONE:    if (out_ready) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Saturating RUN-cycle counter; the terminating cycle is included.
    assign cntInc = (cnt == '1) ? cnt : cnt + CNT_WIDTH'(1);

    // One algorithm iteration, evaluated from the current operand registers.
    always_comb begin
        opANext     = opA;
        opBNext     = opB;
        shiftKNext  = shiftK;
        finish      = 1'b0;
        resultValue = '0;
        if (ALGO == 0) begin
            if (opA == '0 || opB == '0) begin
                finish      = 1'b1;
                resultValue = opA | opB;
            end else if (opA == opB) begin
                finish      = 1'b1;
                resultValue = opA;
            end else if (opA > opB) begin
                opANext = opA - opB;
            end else begin
                opBNext = opB - opA;
            end
        end else begin
            if (opA == '0 || opB == '0) begin
                finish      = 1'b1;
                resultValue = (opA | opB) << shiftK;
            end else if (!opA[0] && !opB[0]) begin
                opANext    = opA >> 1;
                opBNext    = opB >> 1;
                shiftKNext = shiftK + K_WIDTH'(1);
            end else if (!opA[0]) begin
                opANext = opA >> 1;
            end else if (!opB[0]) begin
                opBNext = opB >> 1;
            end else if (opA >= opB) begin
                opANext = (opA - opB) >> 1;
            end else begin
                opBNext = (opB - opA) >> 1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            opA        <= '0;
            opB        <= '0;
            shiftK     <= '0;
            cnt        <= '0;
            out_gcd    <= '0;
            out_cycles <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        opA    <= in_a;
                        opB    <= in_b;
                        shiftK <= '0;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    // Abort abandons the operands; nothing reaches the output registers.
                    if (!abort) begin
                        opA    <= opANext;
                        opB    <= opBNext;
                        shiftK <= shiftKNext;
                        cnt    <= cntInc;
                        if (finish) begin
                            out_gcd    <= resultValue;
                            out_cycles <= cntInc;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_engine.sv
// Scoreboard bench for gcd_engine: three instances (Euclid, Stein, Euclid with a 4-bit counter)
// driven in lockstep, checked against a modulo-based gcd and step-count reference model.
module tb_gcd_engine;

    localparam int NDUT = 3;

    typedef struct {
        int unsigned gcd;
        int unsigned cycles;
    } expEntry;

    logic        clk = 1'b0;
    logic        reset;
    logic        inValid;
    logic [15:0] inA;
    logic [15:0] inB;
    logic        abort;
    logic        outReady;

    logic        inReady   [NDUT];
    logic        outValid  [NDUT];
    logic [15:0] outGcd    [NDUT];
    logic [15:0] outCycles [NDUT];
    logic [15:0] cyc0;
    logic [15:0] cyc1;
    logic [3:0]  cyc2;

    int          checks = 0;
    int          errors = 0;
    expEntry     expQ [NDUT][$];
    int unsigned expN [NDUT];
    bit          held [NDUT];
    logic [15:0] heldGcd [NDUT];
    logic [15:0] heldCyc [NDUT];

    always #5 clk = ~clk;

    always_comb begin
        outCycles[0] = cyc0;
        outCycles[1] = cyc1;
        outCycles[2] = {12'd0, cyc2};
    end

    gcd_engine #(.WIDTH(16), .ALGO(0), .CNT_WIDTH(16)) dutEuclid (
        .clk(clk), .reset(reset), .in_valid(inValid), .in_ready(inReady[0]),
        .in_a(inA), .in_b(inB), .abort(abort), .out_valid(outValid[0]),
        .out_ready(outReady), .out_gcd(outGcd[0]), .out_cycles(cyc0)
    );

    gcd_engine #(.WIDTH(16), .ALGO(1), .CNT_WIDTH(16)) dutStein (
        .clk(clk), .reset(reset), .in_valid(inValid), .in_ready(inReady[1]),
        .in_a(inA), .in_b(inB), .abort(abort), .out_valid(outValid[1]),
        .out_ready(outReady), .out_gcd(outGcd[1]), .out_cycles(cyc1)
    );

    gcd_engine #(.WIDTH(16), .ALGO(0), .CNT_WIDTH(4)) dutSat (
        .clk(clk), .reset(reset), .in_valid(inValid), .in_ready(inReady[2]),
        .in_a(inA), .in_b(inB), .abort(abort), .out_valid(outValid[2]),
        .out_ready(outReady), .out_gcd(outGcd[2]), .out_cycles(cyc2)
    );

    task automatic check(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int unsigned refGcd(input int unsigned a, input int unsigned b);
        int unsigned t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // Subtractive Euclid stopping at a==b: RUN cycles equal the sum of the division quotients.
    function automatic int unsigned euclidSteps(input int unsigned a, input int unsigned b);
        int unsigned s = 0;
        int unsigned t;
        if (a == 0 || b == 0) return 1;
        while (b != 0) begin
            s += a / b;
            t = a % b;
            a = b;
            b = t;
        end
        return s;
    endfunction

    function automatic int unsigned steinSteps(input int unsigned a, input int unsigned b);
        int unsigned s = 0;
        while (a != 0 && b != 0) begin
            s++;
            if (a % 2 == 0 && b % 2 == 0) begin
                a /= 2;
                b /= 2;
            end else if (a % 2 == 0) a /= 2;
            else if (b % 2 == 0) b /= 2;
            else if (a >= b) a = (a - b) / 2;
            else b = (b - a) / 2;
        end
        return s + 1;
    endfunction

    function automatic int unsigned sat(input int unsigned v, input int unsigned maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    function automatic bit allReady();
        return inReady[0] && inReady[1] && inReady[2];
    endfunction

    function automatic bit allValid();
        return outValid[0] && outValid[1] && outValid[2];
    endfunction

    function automatic bit anyValid();
        return outValid[0] || outValid[1] || outValid[2];
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        for (int i = 0; i < NDUT; i++) begin
            if (reset) begin
                held[i] = 1'b0;
            end else begin
                if (held[i]) begin
                    check($sformatf("hold_valid[%0d]", i), outValid[i], 1);
                    check($sformatf("hold_gcd[%0d]", i), outGcd[i], heldGcd[i]);
                    check($sformatf("hold_cycles[%0d]", i), outCycles[i], heldCyc[i]);
                end
                held[i] = outValid[i] && !outReady;
                heldGcd[i] = outGcd[i];
                heldCyc[i] = outCycles[i];
                if (outValid[i] && outReady) begin
                    check($sformatf("expected_pending[%0d]", i), expQ[i].size() > 0, 1);
                    if (expQ[i].size() > 0) begin
                        expEntry e;
                        e = expQ[i].pop_front();
                        check($sformatf("gcd[%0d]", i), outGcd[i], e.gcd);
                        check($sformatf("cycles[%0d]", i), outCycles[i], e.cycles);
                    end
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic checkResetValues(input string tag);
        for (int i = 0; i < NDUT; i++) begin
            check($sformatf("%s_in_ready[%0d]", tag, i), inReady[i], 1);
            check($sformatf("%s_out_valid[%0d]", tag, i), outValid[i], 0);
            check($sformatf("%s_out_gcd[%0d]", tag, i), outGcd[i], 0);
            check($sformatf("%s_out_cycles[%0d]", tag, i), outCycles[i], 0);
        end
    endtask

    task automatic acceptTxn(input logic [15:0] a, input logic [15:0] b, input bit expectResult);
        int budget = 0;
        int unsigned g;
        while (!allReady() && budget < 100) begin
            @(posedge clk);
            #1;
            budget++;
        end
        check("accept_ready", allReady(), 1);
        g = refGcd(a, b);
        expN[0] = euclidSteps(a, b);
        expN[1] = steinSteps(a, b);
        expN[2] = expN[0];
        if (expectResult) begin
            expQ[0].push_back('{g, sat(expN[0], 65535)});
            expQ[1].push_back('{g, sat(expN[1], 65535)});
            expQ[2].push_back('{g, sat(expN[2], 15)});
        end
        inValid = 1'b1;
        inA = a;
        inB = b;
        @(posedge clk);
        #1;
        inValid = 1'b0;
        inA = 16'($urandom);
        inB = 16'($urandom);
    endtask

    // Latency counts the accepting edge as edge 1; out_valid must be seen after edge N+1.
    task automatic finishTxn(input string tag);
        int  lat [NDUT];
        int  edgeNo = 1;
        bit  done = 1'b0;
        for (int i = 0; i < NDUT; i++) lat[i] = 0;
        while (!done && edgeNo < 70000) begin
            @(posedge clk);
            #1;
            edgeNo++;
            for (int i = 0; i < NDUT; i++) begin
                if (outValid[i] && lat[i] == 0) lat[i] = edgeNo;
            end
            done = allReady() && !anyValid() && lat[0] != 0 && lat[1] != 0 && lat[2] != 0;
        end
        check({tag, "_complete"}, done, 1);
        for (int i = 0; i < NDUT; i++) begin
            check($sformatf("%s_latency[%0d]", tag, i), lat[i], expN[i] + 1);
        end
    endtask

    task automatic run(input logic [15:0] a, input logic [15:0] b, input string tag);
        acceptTxn(a, b, 1'b1);
        finishTxn(tag);
    endtask

    task automatic waitAllValid(input string tag);
        int budget = 0;
        while (!allValid() && budget < 200) begin
            @(posedge clk);
            #1;
            budget++;
        end
        check({tag, "_valid"}, allValid(), 1);
    endtask

    initial begin
        reset = 1'b1;
        inValid = 1'b0;
        inA = '0;
        inB = '0;
        abort = 1'b0;
        outReady = 1'b1;
        #2;
        checkResetValues("por");
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        run(16'd48, 16'd18, "t48_18");
        run(16'd0, 16'd0, "z0_0");
        run(16'd7, 16'd0, "z7_0");
        run(16'd0, 16'd255, "z0_255");
        run(16'd65535, 16'd1, "big");
        run(16'd40, 16'd1, "sat40");

        // Backpressure: result held, in_valid pulses and an abort in DONE are ignored.
        outReady = 1'b0;
        acceptTxn(16'd21, 16'd14, 1'b1);
        waitAllValid("bp");
        for (int c = 0; c < 10; c++) begin
            inValid = c[0];
            inA = 16'd3;
            inB = 16'd9;
            abort = (c == 4);
            @(posedge clk);
            #1;
            for (int i = 0; i < NDUT; i++) begin
                check($sformatf("bp_in_ready[%0d]", i), inReady[i], 0);
                check($sformatf("bp_gcd[%0d]", i), outGcd[i], refGcd(21, 14));
            end
        end
        inValid = 1'b0;
        abort = 1'b0;
        outReady = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < NDUT; i++) begin
            check($sformatf("bp_release_ready[%0d]", i), inReady[i], 1);
            check($sformatf("bp_release_valid[%0d]", i), outValid[i], 0);
        end

        // Abort on the third RUN cycle.
        acceptTxn(16'd1000, 16'd3, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        for (int i = 0; i < NDUT; i++) begin
            check($sformatf("abort_ready[%0d]", i), inReady[i], 1);
            check($sformatf("abort_valid[%0d]", i), outValid[i], 0);
        end
        repeat (5) @(posedge clk);
        #1;
        check("abort_no_output", anyValid(), 0);

        // Abort held high across an IDLE accept has no effect.
        abort = 1'b1;
        acceptTxn(16'd12, 16'd8, 1'b1);
        abort = 1'b0;
        finishTxn("t12_8");

        // Asynchronous reset in the middle of RUN.
        acceptTxn(16'd200, 16'd3, 1'b0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checkResetValues("rst_run");
        @(negedge clk);
        #1;
        reset = 1'b0;

        // Asynchronous reset while holding a result in DONE.
        outReady = 1'b0;
        acceptTxn(16'd0, 16'd5, 1'b0);
        waitAllValid("rst_done");
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checkResetValues("rst_done");
        @(negedge clk);
        #1;
        reset = 1'b0;
        outReady = 1'b1;
        run(16'd9, 16'd6, "t9_6");

        for (int n = 0; n < 25; n++) begin
            run(16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)), $sformatf("rnd%0d", n));
        end

        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < NDUT; i++) begin
            check($sformatf("drained[%0d]", i), expQ[i].size(), 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #3_000_000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
